des_round_controller: RTL
=========================

DES_ROUND_CONTROLLER -- requirements
Module: des_round_controller

Interface
REQ-001 SHALL provide parameter ROUNDS, default 16, number of Feistel rounds; only the value 16 is supported.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, a new block/key pair is offered.
REQ-005 SHALL have port in_ready, output, 1, the controller accepts the offered pair.
REQ-006 SHALL have port in_block, input, 64, plaintext or ciphertext; bit 0 = DES bit 1.
REQ-007 SHALL have port in_key, input, 64, key with parity bits; bit 0 = DES bit 1.
REQ-008 SHALL have port in_decrypt, input, 1; 1 = decrypt, 0 = encrypt.
REQ-009 SHALL have port f_r, output, 32, current R half driven to the external f-function.
REQ-010 SHALL have port f_k, output, 48, current round subkey (PC-2 of C,D).
REQ-011 SHALL have port f_out, input, 32, combinational f(f_r, f_k) result.
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-014 SHALL have port out_block, output, 64, final-permuted result.
REQ-015 SHALL have port busy, output, 1, high in the LOAD, ROUND and DONE states.
REQ-016 SHALL have port round_cnt, output, 5, current round 1..16; 0 outside ROUND.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, ROUND and DONE.
REQ-018 SHALL, in IDLE, assert in_ready; in_valid&&in_ready accepts the pair, moves to LOAD and latches in_decrypt.
REQ-019 SHALL, in LOAD, register {L,R} = IP(in_block copy) and {C,D} = PC-1(in_key copy), then enter ROUND with round_cnt=1.
REQ-020 SHALL apply IP per the standard DES table, including output bit 63 sourced from input bit 6.
REQ-021 SHALL perform exactly one round per ROUND cycle: L'=R, R'=L^f_out; f_k uses C,D after this round's shift.
REQ-022 SHALL, for encrypt round r, left-rotate C,D by S[r], where S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-023 SHALL, for decrypt, apply no rotation in round 1 and right-rotate C,D by S[18-r] in round r>1.
REQ-024 SHALL rotate each 28-bit half independently with wrap-around, never across C/D.
REQ-025 SHALL, after round 16, register out_block = FP({R,L}) (swap undone), enter DONE and assert out_valid.
REQ-026 SHALL, in DONE, hold out_valid and out_block stable until out_ready, then return to IDLE in the same edge.
REQ-027 SHALL give a latency of exactly 18 cycles from the accept edge to the first out_valid cycle.
REQ-028 SHALL keep in_ready low while busy; in_valid outside IDLE is ignored, not queued.
REQ-029 SHALL leave out_valid and in_ready mutually exclusive; back-to-back throughput is one block per 19 cycles minimum.
REQ-030 SHALL drive f_r and f_k from registered state only, never combinationally from in_*.

Reset
REQ-031 SHALL, on rst asserted at any time including mid-round, abort: state=IDLE, L,R,C,D=0, out_block=0, out_valid=0, busy=0, round_cnt=0.
REQ-032 SHALL assert in_ready in the first cycle after rst deasserts.

Structure
REQ-033 SHALL place the state enum, shift schedule S and the IP/FP/PC-1/PC-2 index tables in shared package des_pkg.
REQ-034 SHALL implement C,D rotation and PC-2 in one sub-module des_key_sched (inputs C,D, shift amount, direction; output next C,D and subkey).
REQ-035 SHALL instantiate IP and FP as the codebase's combinational permutation blocks, keeping S-boxes and the f-function outside this module.

Verification (hex strings in DES bit order: MSB = bit 0)
REQ-036 SHALL cover encrypt: key 133457799BBCDFF1, block 0123456789ABCDEF -> out_block 85E813540F0AB405 exactly 18 cycles after accept.
REQ-037 SHALL cover decrypt: same key, block 85E813540F0AB405 -> 0123456789ABCDEF; f_k in round 1 equals the encrypt round-16 subkey.
REQ-038 SHALL cover backpressure: out_ready low for 5 cycles in DONE -> out_valid and out_block held, in_ready low, then IDLE one edge after out_ready.
REQ-039 SHALL cover reset mid-operation: rst pulsed at round_cnt=7 -> all outputs zero immediately; a next encrypt gives the correct result.
REQ-040 SHALL cover ignored input: in_valid toggled with random data during ROUND -> result unchanged from REQ-036.
REQ-041 SHALL cover rotation wrap: after round 16 (encrypt), C,D equal their PC-1 values (28 total shifts).

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: controller states, key shift schedule and the
// standard permutation tables (entries are 1-based DES bit positions).
package des_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_DONE} state_e;
   typedef enum logic [1:0] {PERM_IP, PERM_FP, PERM_PC1, PERM_PC2} perm_e;

   localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   localparam int IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

   localparam int FP_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
      38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
      34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

   localparam int PC1_T [56] = '{
      57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
      10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
      63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
      14,6,61,53,45,37,29,  21,13,5,28,20,12,4};

   localparam int PC2_T [48] = '{
      14,17,11,24,1,5,   3,28,15,6,21,10,
      23,19,12,4,26,8,   16,7,27,20,13,2,
      41,52,31,37,47,55, 30,40,51,45,33,48,
      44,49,39,56,34,53, 46,42,50,36,29,32};

   function automatic int perm_src(input perm_e kind, input int j);
      case (kind)
         PERM_IP:  return IP_T[j];
         PERM_FP:  return FP_T[j];
         PERM_PC1: return PC1_T[j];
         default:  return PC2_T[j];
      endcase
   endfunction

   // Decrypt walks the schedule backwards: round 1 reuses C0,D0 (= C16,D16).
   function automatic logic [1:0] shift_amt(input logic [4:0] rnd, input logic dec);
      if (rnd == 5'd0 || rnd > 5'd16) return 2'd0;
      if (dec) return (rnd == 5'd1) ? 2'd0 : 2'(SHIFTS[17 - int'(rnd)]);
      return 2'(SHIFTS[int'(rnd) - 1]);
   endfunction

endpackage

// File: rtl/des_key_sched.sv
// One key-schedule step: rotate C and D independently, then PC-2.
module des_key_sched
   import des_pkg::*;
(
   input  logic [27:0] c,
   input  logic [27:0] d,
   input  logic [1:0]  shamt,
   input  logic        right,
   output logic [27:0] c_nxt,
   output logic [27:0] d_nxt,
   output logic [47:0] subkey
);

   // DES left rotate moves bit k+s to bit k, i.e. a right shift of the vector.
   function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] s,
                                         input logic rt);
      logic [55:0] dbl, lft, rgt;
      dbl = {x, x};
      lft = dbl >> s;
      rgt = dbl << s;
      return rt ? rgt[55:28] : lft[27:0];
   endfunction

   assign c_nxt = rot28(c, shamt, right);
   assign d_nxt = rot28(d, shamt, right);

   des_perm #(.KIND(PERM_PC2), .IN_W(56), .OUT_W(48)) u_pc2 (
      .din  ({d_nxt, c_nxt}),
      .dout (subkey)
   );

endmodule

// File: rtl/des_perm.sv
// Combinational bit permutation; dout[j] = din[table[j]-1], bit 0 = DES bit 1.
module des_perm
   import des_pkg::*;
#(
   parameter perm_e KIND  = PERM_IP,
   parameter int    IN_W  = 64,
   parameter int    OUT_W = 64
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout
);

   // PC-1 drops parity bits and PC-2 drops eight key bits by design.
   logic din_unused;
   assign din_unused = ^din;

   for (genvar j = 0; j < OUT_W; j++) begin : g_bit
      localparam int SRC = perm_src(KIND, j) - 1;
      assign dout[j] = din[SRC];
   end

endmodule

// File: rtl/des_round_controller.sv
// Iterative DES datapath controller: one Feistel round per cycle, external
// f-function, IP/FP and key schedule held locally.
module des_round_controller
   import des_pkg::*;
#(
   parameter int ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_block,
   input  logic [63:0] in_key,
   input  logic        in_decrypt,
   output logic [31:0] f_r,
   output logic [47:0] f_k,
   input  logic [31:0] f_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_block,
   output logic        busy,
   output logic [4:0]  round_cnt
);

   state_e      state;
   logic        dec;
   logic [63:0] blk_q, key_q;
   logic [31:0] l, r;
   logic [27:0] c, d;
   logic [4:0]  rnd;

   logic [63:0] ip_out, fp_out;
   logic [55:0] pc1_out;
   logic [27:0] c_nxt, d_nxt;
   logic [31:0] r_nxt;
   logic [1:0]  shamt;

   assign r_nxt = l ^ f_out;
   assign shamt = shift_amt(rnd, dec);

   des_perm #(.KIND(PERM_IP),  .IN_W(64), .OUT_W(64)) u_ip  (.din(blk_q), .dout(ip_out));
   des_perm #(.KIND(PERM_PC1), .IN_W(64), .OUT_W(56)) u_pc1 (.din(key_q), .dout(pc1_out));
   // Final round output is {R16,L16} in DES order: R16 occupies bits 0..31.
   des_perm #(.KIND(PERM_FP),  .IN_W(64), .OUT_W(64)) u_fp  (.din({r, r_nxt}), .dout(fp_out));

   des_key_sched u_ks (
      .c      (c),
      .d      (d),
      .shamt  (shamt),
      .right  (dec),
      .c_nxt  (c_nxt),
      .d_nxt  (d_nxt),
      .subkey (f_k)
   );

   assign f_r       = r;
   assign in_ready  = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign round_cnt = rnd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         dec       <= 1'b0;
         blk_q     <= '0;
         key_q     <= '0;
         l         <= '0;
         r         <= '0;
         c         <= '0;
         d         <= '0;
         rnd       <= '0;
         out_block <= '0;
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               blk_q <= in_block;
               key_q <= in_key;
               dec   <= in_decrypt;
               state <= ST_LOAD;
            end
            ST_LOAD: begin
               {r, l} <= ip_out;
               {d, c} <= pc1_out;
               rnd    <= 5'd1;
               state  <= ST_ROUND;
            end
            ST_ROUND: begin
               l <= r;
               r <= r_nxt;
               c <= c_nxt;
               d <= d_nxt;
               if (rnd == 5'(ROUNDS)) begin
                  out_block <= fp_out;
                  rnd       <= '0;
                  state     <= ST_DONE;
               end else begin
                  rnd <= rnd + 5'd1;
               end
            end
            ST_DONE: if (out_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
